// File: rtl/dct_quant_zigzag.sv
// dct_quant_zigzag: captures an 8x8 DCT block, quantizes with rounding and streams it in zigzag order
// Ports:
//   Clock, reset       rising-edge clock, asynchronous active-high reset
//   coef_valid_i       level; high while coef_in_i holds a finished block
//   coef_in_i[703:0]   coefficient (r,c) at [(r*8+c)*11+:11], two's complement
//   busy_o             high from capture until the last element is accepted
//   out_valid_o        out_data_o/out_index_o/out_last_o valid
//   out_ready_i        consumer accepts on an edge where out_valid_o && out_ready_i
//   out_data_o[10:0]   quantized coefficient, signed
//   out_index_o[5:0]   zigzag position k
//   out_last_o         high with k=63
//   block_done_o       one-cycle pulse after the last element is accepted
//   last_nz_o[6:0]     (highest k with nonzero output)+1, valid while block_done_o
module dct_quant_zigzag #(
  parameter logic [511:0] QTABLE = 512'h63676470625F5C48_65787967574E4031_5C71685140372318_4D676D4438251612_3E5057331D16110E_3845392818100D0E_373C3A1A130E0C0C_3D332818100A0B10
) (
  input  logic         Clock,
  input  logic         reset,
  input  logic         coef_valid_i,
  input  logic [703:0] coef_in_i,
  output logic         busy_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [10:0]  out_data_o,
  output logic [5:0]   out_index_o,
  output logic         out_last_o,
  output logic         block_done_o,
  output logic [6:0]   last_nz_o
);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  localparam logic [63:0][7:0] QT = QTABLE;
  localparam logic [5:0] ZZ [64] = '{
    6'd0, 6'd1, 6'd8, 6'd16, 6'd9, 6'd2, 6'd3, 6'd10, 6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4, 6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34, 6'd27, 6'd20, 6'd13, 6'd6, 6'd7, 6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36, 6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46, 6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63};
  state_t            state_q, state_d;
  logic [63:0][10:0] coef_q, coef_d;
  logic              armed_q, armed_d;
  logic [5:0]        k_q, k_d;
  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic [10:0]       out_data_q, out_data_d;
  logic [5:0]        out_index_q, out_index_d;
  logic              out_last_q, out_last_d;
  logic              block_done_q, block_done_d;
  logic [6:0]        last_nz_q, last_nz_d;
  logic [5:0]        pos;
  logic [10:0]       c;
  logic [7:0]        div;
  logic [11:0]       mag, num, q;
  logic [10:0]       qv;
  logic              capture, accept;
  // Quantizer for the element k_q will load next; a zero table entry divides by 1.
  // Magnitude is taken in 12 bits so that -1024 yields 1024.
  always_comb begin
    pos = ZZ[k_q];
    c   = coef_q[pos];
    div = (QT[pos] == 8'd0) ? 8'd1 : QT[pos];
    mag = c[10] ? ~{c[10], c} + 12'd1 : {1'b0, c};
    num = mag + {5'd0, div[7:1]};
    q   = num / {4'd0, div};
    qv  = c[10] ? 11'(12'd0 - q) : q[10:0];
  end
  assign capture = (state_q == IDLE) && coef_valid_i && armed_q;
  assign accept  = out_valid_q && out_ready_i;
  always_comb begin
    state_d      = state_q;
    coef_d       = coef_q;
    k_d          = k_q;
    busy_d       = busy_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_index_d  = out_index_q;
    out_last_d   = out_last_q;
    block_done_d = 1'b0;
    last_nz_d    = last_nz_q;
    // coef_valid_i is a level: a block is taken once, then re-armed only after it drops
    armed_d      = capture ? 1'b0 : (!coef_valid_i ? 1'b1 : armed_q);
    case (state_q)
      IDLE: if (capture) begin
        coef_d    = coef_in_i;
        busy_d    = 1'b1;
        k_d       = 6'd0;
        last_nz_d = 7'd0;
        state_d   = STREAM;
      end
      STREAM: begin
        if (accept && out_data_q != 11'd0) last_nz_d = {1'b0, out_index_q} + 7'd1;
        if (accept && out_last_q) begin
          out_valid_d  = 1'b0;
          out_last_d   = 1'b0;
          busy_d       = 1'b0;
          block_done_d = 1'b1;
          state_d      = DONE;
        end else if (!out_valid_q || accept) begin
          out_valid_d = 1'b1;
          out_data_d  = qv;
          out_index_d = k_q;
          out_last_d  = (k_q == 6'd63);
          k_d         = k_q + 6'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      coef_q       <= '0;
      armed_q      <= 1'b1;
      k_q          <= 6'd0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 11'd0;
      out_index_q  <= 6'd0;
      out_last_q   <= 1'b0;
      block_done_q <= 1'b0;
      last_nz_q    <= 7'd0;
    end else begin
      state_q      <= state_d;
      coef_q       <= coef_d;
      armed_q      <= armed_d;
      k_q          <= k_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_index_q  <= out_index_d;
      out_last_q   <= out_last_d;
      block_done_q <= block_done_d;
      last_nz_q    <= last_nz_d;
    end
  end
  assign busy_o       = busy_q;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign out_index_o  = out_index_q;
  assign out_last_o   = out_last_q;
  assign block_done_o = block_done_q;
  assign last_nz_o    = last_nz_q;
endmodule
